// File: rtl/xpu_vpu_pc_clk_gate_ctrl.sv
// Clock-gate controller for the VPU power domain: wakes the gated clock on request,
// grants requesters once stable, and gates it again after a programmable idle hysteresis.
module xpu_vpu_pc_clk_gate_ctrl #(
  parameter int N_REQ    = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_W   = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  busy,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic              cfg_force_on,
  output logic              local_en,
  output logic [N_REQ-1:0]  ack,
  output logic [1:0]        gate_state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [2:0]          wake_cnt_r;
  logic [2:0]          wake_cnt_nxt_s;
  logic [IDLE_W-1:0]   idle_cnt_r;
  logic [IDLE_W-1:0]   idle_cnt_nxt_s;
  logic                active_s;

  assign active_s   = (|req) | (|busy) | cfg_force_on;
  assign gate_state = state_r;

  // Next-state and counter update; activity is checked before idle expiry so wake wins a race.
  always_comb begin
    state_nxt_s    = state_r;
    wake_cnt_nxt_s = wake_cnt_r;
    idle_cnt_nxt_s = idle_cnt_r;
    case (state_r)
      ST_OFF: begin
        if ((|req) || cfg_force_on) begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = 3'(WAKE_CYC - 1);
        end else begin
          state_nxt_s    = ST_OFF;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r == 3'd0) begin
          state_nxt_s    = ST_ON;
        end else begin
          wake_cnt_nxt_s = wake_cnt_r - 3'd1;
        end
      end
      ST_ON: begin
        if (!active_s) begin
          state_nxt_s    = ST_IDLE;
          idle_cnt_nxt_s = cfg_idle_thr;
        end else begin
          state_nxt_s    = ST_ON;
        end
      end
      ST_IDLE: begin
        if (active_s) begin
          state_nxt_s    = ST_ON;
          idle_cnt_nxt_s = '0;
        end else if (idle_cnt_r == '0) begin
          state_nxt_s    = ST_OFF;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r - IDLE_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_OFF;
        wake_cnt_nxt_s = 3'd0;
        idle_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, counters and flop-driven outputs; local_en follows the next state so it is glitch-free.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r    <= ST_OFF;
      wake_cnt_r <= 3'd0;
      idle_cnt_r <= '0;
      local_en   <= 1'b0;
      ack        <= {N_REQ{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      local_en   <= (state_nxt_s != ST_OFF);
      ack        <= ((state_r == ST_ON) && (state_nxt_s == ST_ON)) ? req : {N_REQ{1'b0}};
    end
  end

endmodule

// File: tb/tb_xpu_vpu_pc_clk_gate_ctrl.sv
// Scenario bench for the clock-gate controller: each scenario queues per-cycle stimulus
// with the expected {local_en, ack, gate_state} and checks it cycle by cycle.
module tb_xpu_vpu_pc_clk_gate_ctrl;

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_WAKE = 2'b01;
  localparam logic [1:0] S_ON   = 2'b10;
  localparam logic [1:0] S_IDLE = 2'b11;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] busy = 4'b0000;
  logic [7:0] cfg_idle_thr = 8'd0;
  logic       cfg_force_on = 1'b0;
  logic       local_en;
  logic [3:0] ack;
  logic [1:0] gate_state;
  logic [6:0] obs;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] busy;
    logic       force_on;
    logic [7:0] thr;
  } stim_t;

  stim_t      stim_q[$];
  logic [6:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  xpu_vpu_pc_clk_gate_ctrl dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .req          (req),
    .busy         (busy),
    .cfg_idle_thr (cfg_idle_thr),
    .cfg_force_on (cfg_force_on),
    .local_en     (local_en),
    .ack          (ack),
    .gate_state   (gate_state)
  );

  always #5 clk_in = ~clk_in;
  assign obs = {local_en, ack, gate_state};

  function automatic logic [6:0] ex(input logic en, input logic [3:0] a, input logic [1:0] st);
    return {en, a, st};
  endfunction

  task automatic sched(input logic r_rst, input logic [3:0] r, input logic [3:0] b,
                       input logic f, input logic [7:0] t, input logic [6:0] e);
    stim_t s;
    s.rst = r_rst; s.req = r; s.busy = b; s.force_on = f; s.thr = t;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply_tick(input stim_t s);
    rst = s.rst; req = s.req; busy = s.busy; cfg_force_on = s.force_on; cfg_idle_thr = s.thr;
    @(posedge clk_in);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = 4'b0000; busy = 4'b0000; cfg_force_on = 1'b0;
    @(posedge clk_in);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s; logic [6:0] e; int k = 0;
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== ex(1'b0, 4'b0000, S_OFF)) begin
      n_fail++; $display("FAIL reset_async: got %b expected %b", obs, ex(1'b0, 4'b0000, S_OFF));
    end
    for (int i = 0; i < 3; i++) sched(1'b1, 4'b0001, 4'b0000, 1'b0, 8'd0, ex(1'b0, 4'b0000, S_OFF));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0001, S_ON));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_cold_wake();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b0001, S_ON));
    sched(1'b0, 4'b1001, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b1001, S_ON));
    sched(1'b0, 4'b1000, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b1000, S_ON));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd3, ex(1'b1, 4'b0000, S_IDLE));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL cold_wake step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_idle_gating();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0001, S_ON));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_IDLE));
    // threshold change mid-IDLE must not shorten the current countdown
    for (int i = 0; i < 5; i++) sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd1, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd1, ex(1'b0, 4'b0000, S_OFF));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0010, S_ON));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0, ex(1'b0, 4'b0000, S_OFF));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL idle_gating step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_rewake_idle();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0100, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0100, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0100, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0100, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0100, S_ON));
    for (int i = 0; i < 3; i++) sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0000, 4'b0100, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0000, 4'b0100, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_IDLE));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL rewake_idle step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_race();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0010, S_ON));
    for (int i = 0; i < 3; i++) sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0010, 4'b0000, 1'b0, 8'd2, ex(1'b1, 4'b0010, S_ON));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL race step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_force_on();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    for (int i = 0; i < 4; i++) sched(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_IDLE));
    sched(1'b0, 4'b0000, 4'b0000, 1'b1, 8'd5, ex(1'b1, 4'b0000, S_ON));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL force_on step %0d: got %b expected %b", k, obs, e); end
      k++;
    end
  endtask

  task automatic test_reset_mid_wake();
    stim_t s; logic [6:0] e; int k = 0;
    reset_dut();
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b1, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b0, 4'b0000, S_OFF));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_WAKE));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0000, S_ON));
    sched(1'b0, 4'b0001, 4'b0000, 1'b0, 8'd5, ex(1'b1, 4'b0001, S_ON));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); apply_tick(s); e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid_wake step %0d: got %b expected %b", k, obs, e); end
      k++;
      if (k == 1) begin
        // asynchronous assertion between edges must clear outputs with no clock edge
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== ex(1'b0, 4'b0000, S_OFF)) begin
          n_fail++; $display("FAIL reset_mid_wake async: got %b expected %b", obs, ex(1'b0, 4'b0000, S_OFF));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_wake();
    test_idle_gating();
    test_rewake_idle();
    test_race();
    test_force_on();
    test_reset_mid_wake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/xpu_vpu_pc_clk_gate_ctrl.md
XPU_VPU_PC_CLK_GATE_CTRL -- requirements
Module: xpu_vpu_pc_clk_gate_ctrl

Interface
REQ-001 Parameter: N_REQ, default 4, number of clock requesters.
REQ-002 Parameter: WAKE_CYC, default 2, cycles from gate-enable to grant, legal range 1..7.
REQ-003 Parameter: IDLE_W, default 8, width of the idle hysteresis counter.
REQ-004 clk_in  input  1  free-running ungated clock; the sole clock of this block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester clock request, level, held until released by requester.
REQ-007 busy  input  N_REQ  per-requester activity in gated domain, sampled on clk_in.
REQ-008 cfg_idle_thr  input  IDLE_W  idle cycles required before gating; 0 means gate on first idle cycle.
REQ-009 cfg_force_on  input  1  1 = clock held on, never gates.
REQ-010 local_en  output  1  enable to root gated-clock cell local_en pin, registered.
REQ-011 ack  output  N_REQ  per-requester grant: gated clock is running and stable.
REQ-012 gate_state  output  2  current FSM state encoding, for debug.

Function
REQ-013 FSM states SHALL be OFF=2'b00, WAKE=2'b01, ON=2'b10, IDLE=2'b11.
REQ-014 OFF: local_en=0, ack=0; any req bit or cfg_force_on=1 -> WAKE next cycle.
REQ-015 WAKE: local_en=1; wake counter loads WAKE_CYC-1 on entry, decrements each cycle; at 0 -> ON.
REQ-016 WAKE with all req=0, all busy=0, cfg_force_on=0 SHALL still complete to ON (no abort mid-wake).
REQ-017 ON: local_en=1; ack[i]=req[i] registered (one-cycle latency from req rise in ON).
REQ-018 ON -> IDLE when req==0 and busy==0 and cfg_force_on==0; idle counter loads cfg_idle_thr.
REQ-019 IDLE: local_en=1, ack=0; counter decrements each cycle; counter==0 with still idle -> OFF.
REQ-020 IDLE: any req, any busy, or cfg_force_on -> ON next cycle, idle counter discarded.
REQ-021 Simultaneous req rise and idle counter reaching 0 SHALL resolve to ON (wake wins).
REQ-022 Total cycles from entering IDLE to local_en=0 SHALL be cfg_idle_thr+1 with no activity.
REQ-023 ack SHALL only be 1 in ON; ack[i] SHALL fall the cycle after req[i] falls.
REQ-024 cfg_idle_thr changes SHALL take effect only at the next ON->IDLE load.
REQ-025 local_en SHALL be driven directly from a flop (glitch-free into ICG latch).
REQ-026 Latency req rise in OFF -> ack: 1 (OFF->WAKE) + WAKE_CYC + 1 cycles; 4 at default.

Reset
REQ-027 While rst=1: state=OFF, local_en=0, ack=0, wake and idle counters=0.
REQ-028 Reset mid-WAKE, ON or IDLE SHALL force OFF immediately (asynchronous); first post-reset transition evaluated at the first clk_in edge after rst falls.
REQ-029 Pending req at reset release SHALL start a normal wake from OFF.

Verification
REQ-030 Cold wake: req=4'b0001 at cycle 0 from OFF -> local_en=1 at cycle 1, ack=4'b0001 at cycle 4 (default params).
REQ-031 Idle gating: cfg_idle_thr=5, drop req and busy in ON -> IDLE next cycle, local_en=0 exactly 6 cycles after IDLE entry.
REQ-032 Re-wake in IDLE: cfg_idle_thr=5, assert busy[2] after 3 IDLE cycles -> ON next cycle, local_en stays 1 throughout.
REQ-033 Race: req[1] rises the cycle idle counter reaches 0 -> state ON, local_en never drops, ack[1]=1 one cycle later.
REQ-034 Force-on: cfg_force_on=1 with req=0, busy=0 -> reaches ON, never enters IDLE; cfg_force_on=0 -> IDLE next cycle.
REQ-035 Reset mid-WAKE: rst=1 during WAKE -> local_en=0, gate_state=2'b00 without clock edge; req held -> ack after 4 cycles from first edge post-release.
